// File: rtl/demux_dispatch_pkg.sv
// Shared types and the masked round-robin search for the 1-to-4 demux dispatcher.
package demux_dispatch_pkg;

  localparam int unsigned NCH = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    StEmpty,
    StFull
  } state_e;

  typedef struct packed {
    logic found;
    sel_t idx;
  } pick_t;

  // First set bit of mask, scanning start, start+1, ... modulo NCH.
  function automatic pick_t rr_next(sel_t start, logic [NCH-1:0] mask);
    pick_t res;
    sel_t  cand;
    res.found = 1'b0;
    res.idx   = start;
    for (int i = NCH - 1; i >= 0; i--) begin
      cand = start + sel_t'(i);
      if (mask[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/demux_dispatch_1to4_rr_pick4.sv
// Combinational masked round-robin channel picker for the dispatcher.
module rr_pick4
  import demux_dispatch_pkg::*;
(
  input  sel_t       start,
  input  logic [3:0] mask,
  output sel_t       idx,
  output logic       found
);

  pick_t res;

  always_comb begin
    res   = rr_next(start, mask);
    idx   = res.idx;
    found = res.found;
  end

endmodule

// File: rtl/demux_dispatch_1to4.sv
// Round-robin 1-to-4 dispatcher with a one-entry holding stage.
// Define DEMUX_DISPATCH_MASK_EN to skip channels whose ch_en bit is clear.
module demux_dispatch_1to4
  import demux_dispatch_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  input  logic [3:0]       ch_en,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [W-1:0]     out_data,
  output logic [1:0]       out_sel,
  output logic [CNT_W-1:0] xfer_cnt
);

  state_e         state;
  logic [W-1:0]   hold_data;
  sel_t           sel;
  sel_t           ptr;
  logic           hold_valid;
  logic           xfer;
  logic           accept;
  sel_t           start;
  sel_t           target;
  logic           target_ok;

  assign hold_valid = (state == StFull);
  assign xfer       = hold_valid & out_ready[sel];
  // On a same-cycle transfer the pointer update has not landed yet, so search from sel+1.
  assign start      = xfer ? sel + 2'd1 : ptr;

`ifdef DEMUX_DISPATCH_MASK_EN
  rr_pick4 u_pick (
    .start (start),
    .mask  (ch_en),
    .idx   (target),
    .found (target_ok)
  );
`else
  logic unused_ch_en;
  assign unused_ch_en = ^ch_en;
  assign target       = start;
  assign target_ok    = 1'b1;
`endif

  assign in_ready  = (~hold_valid | xfer) & target_ok;
  assign accept    = in_valid & in_ready;
  assign out_valid = hold_valid ? (4'd1 << sel) : 4'd0;
  assign out_data  = hold_data;
  assign out_sel   = sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StEmpty;
      hold_data <= '0;
      sel       <= '0;
      ptr       <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (xfer) begin
        ptr      <= sel + 2'd1;
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
      if (accept) begin
        hold_data <= in_data;
        sel       <= target;
        state     <= StFull;
      end else if (xfer) begin
        state <= StEmpty;
      end
    end
  end

endmodule

// File: tb/tb_demux_dispatch_1to4.sv
// Scoreboard bench for demux_dispatch_1to4 (CNT_W=4 to exercise counter wrap).
module tb_demux_dispatch_1to4;
  import demux_dispatch_pkg::*;

  localparam int unsigned W     = 8;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   sel;
  } item_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic [3:0]       ch_en;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [W-1:0]     out_data;
  logic [1:0]       out_sel;
  logic [CNT_W-1:0] xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  item_t            sb[$];
  logic             m_full;
  logic [1:0]       m_sel;
  logic [1:0]       m_ptr;
  logic [CNT_W-1:0] m_cnt;

  always #5 clk = ~clk;

  demux_dispatch_1to4 #(
    .W     (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ch_en     (ch_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .xfer_cnt  (xfer_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void pick(input logic [1:0] start, output logic [1:0] tgt,
                               output logic ok);
    tgt = start;
    ok  = 1'b1;
`ifdef DEMUX_DISPATCH_MASK_EN
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] c;
      c = start + 2'(i);
      if (!ok && ch_en[c]) begin
        ok  = 1'b1;
        tgt = c;
      end
    end
`endif
  endfunction

  task automatic model_reset();
    sb.delete();
    m_full = 1'b0;
    m_sel  = 2'd0;
    m_ptr  = 2'd0;
    m_cnt  = '0;
  endtask

  // Check outputs mid-cycle, score the edge that follows, advance the model.
  task automatic step();
    logic [3:0] exp_ov;
    logic [1:0] tgt;
    logic       tok, xf, exp_rdy, acc;
    item_t      it;
    @(negedge clk);
    exp_ov = m_full ? (4'd1 << m_sel) : 4'd0;
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    xf = m_full && out_ready[m_sel];
    pick(xf ? m_sel + 2'd1 : m_ptr, tgt, tok);
    exp_rdy = (!m_full || xf) && tok;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (|(out_valid & out_ready)) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        it = sb.pop_front();
        check("out_data", 32'(out_data), 32'(it.data));
        check("out_sel", 32'(out_sel), 32'(it.sel));
      end
    end
    acc = in_valid && exp_rdy;
    if (xf) begin
      m_ptr = m_sel + 2'd1;
      m_cnt = m_cnt + 1'b1;
    end
    if (acc) begin
      sb.push_back('{data: in_data, sel: tgt});
      m_sel  = tgt;
      m_full = 1'b1;
    end else if (xf) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    ch_en     = 4'b1111;
    out_ready = 4'b1111;
    model_reset();
    #23 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming with all consumers ready: strict rotation, no bubbles.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(i);
      step();
      check("stream_sel", 32'(out_sel), i % 4);
      check("stream_valid", 32'(out_valid), 32'(4'd1 << (i % 4)));
    end
    in_valid = 1'b0;
    step();
    check("stream_cnt", 32'(xfer_cnt), 32'd5);

    // Backpressure on ch1 for three cycles.
    out_ready = 4'b1101;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    step();
    in_data = 8'h66;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 32'(out_valid), 32'b0010);
      check("stall_data", 32'(out_data), 32'h55);
      check("stall_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 4'b1111;
    step();
    check("after_stall_sel", 32'(out_sel), 32'd2);
    in_valid = 1'b0;
    step();

    // Park an item on ch2, then reset mid-transfer.
    out_ready = 4'b1011;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h10 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    check("park_valid", 32'(out_valid), 32'b0100);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_cnt", 32'(xfer_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 4'b1111;

    // 17 transfers from reset: the 4-bit counter wraps to 1.
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 8'(8'h30 + i);
      step();
      if (i == 0) check("post_rst_sel", 32'(out_sel), 32'd0);
    end
    in_valid = 1'b0;
    step();
    check("wrap_cnt", 32'(xfer_cnt), 32'd1);

`ifdef DEMUX_DISPATCH_MASK_EN
    ch_en    = 4'b1010;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'hC0 + 8'(i);
      step();
      check("mask_sel", 32'(out_sel), (i % 2 == 0) ? 32'd1 : 32'd3);
    end
    in_valid = 1'b0;
    step();
    ch_en    = 4'b0000;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      check("mask_zero_ready", 32'(in_ready), 32'd0);
      step();
    end
    check("mask_zero_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    ch_en    = 4'b1111;
    step();
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
